// File: rtl/core_pkg.sv
// Shared core types: store data queue entry layout, pointer type and drain states.
package core_pkg;
  localparam int unsigned SDQ_ENTRIES  = 16;
  localparam int unsigned RETIRE_WIDTH = 2;

  typedef struct packed {
    logic        valid;
    logic        addr_valid;
    logic        committed;
    logic        issued;
    logic [31:0] addr;
    logic [31:0] data;
  } sdq_entry_t;

  typedef logic [$clog2(SDQ_ENTRIES):0] sdq_ptr_t;

  typedef enum logic [1:0] {
    SDQ_IDLE     = 2'd0,
    SDQ_REQ      = 2'd1,
    SDQ_WAIT_ACK = 2'd2
  } sdq_drain_state_t;
endpackage

// File: rtl/sdq_fwd_search.sv
// Age-ordered store-to-load forwarding search over the entries older than a load marker.
module sdq_fwd_search import core_pkg::*; #(
  parameter int unsigned DEPTH = SDQ_ENTRIES
) (
  input  sdq_entry_t               entries [DEPTH],
  input  logic [$clog2(DEPTH):0]   head,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  input  logic [$clog2(DEPTH):0]   ld_marker,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic                     fwd_conflict
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] span;
  logic [IW-1:0] idx;
  logic          hit;
  logic          conflict;
  logic [31:0]   data;
  logic          unused_fields;

  // Walk oldest to youngest: a match wipes earlier unknowns, so only unknowns younger than the hit survive.
  always_comb begin
    span     = ld_marker - head;
    idx      = '0;
    hit      = 1'b0;
    conflict = 1'b0;
    data     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head[IW-1:0] + IW'(k);
      if (PW'(k) < span && entries[idx].valid) begin
        if (!entries[idx].addr_valid) begin
          conflict = 1'b1;
        end else if (entries[idx].addr[31:2] == ld_addr[31:2]) begin
          hit      = 1'b1;
          data     = entries[idx].data;
          conflict = 1'b0;
        end
      end
    end
    fwd_hit      = ld_valid && hit && !conflict;
    fwd_data     = fwd_hit ? data : '0;
    fwd_conflict = ld_valid && conflict;
  end

  always_comb begin
    unused_fields = ^ld_addr[1:0];
    for (int unsigned k = 0; k < DEPTH; k++)
      unused_fields ^= entries[k].committed ^ entries[k].issued ^ (^entries[k].addr[1:0]);
  end
endmodule

// File: rtl/store_data_queue.sv
// Store data queue: in-order allocation, out-of-order writeback, in-order commit and drain to memory.
module store_data_queue import core_pkg::*; #(
  parameter int unsigned DEPTH        = SDQ_ENTRIES,
  parameter int unsigned ALLOC_WIDTH  = 2,
  parameter int unsigned COMMIT_WIDTH = RETIRE_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ALLOC_WIDTH-1:0]                   alloc_req,
  output logic                                     alloc_ready,
  output logic [ALLOC_WIDTH-1:0][$clog2(DEPTH)-1:0] alloc_idx,
  input  logic                                     wr_valid,
  input  logic [$clog2(DEPTH)-1:0]                 wr_idx,
  input  logic [31:0]                              wr_addr,
  input  logic [31:0]                              wr_data,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]        commit_cnt,
  input  logic                                     flush,
  output logic                                     mem_req_valid,
  input  logic                                     mem_req_ready,
  output logic [31:0]                              mem_req_addr,
  output logic [31:0]                              mem_req_data,
  input  logic                                     mem_ack,
  input  logic                                     ld_valid,
  input  logic [31:0]                              ld_addr,
  input  logic [$clog2(DEPTH):0]                   ld_marker,
  output logic                                     fwd_hit,
  output logic [31:0]                              fwd_data,
  output logic                                     fwd_conflict,
  output logic [$clog2(DEPTH):0]                   tail_marker,
  output logic [$clog2(DEPTH):0]                   count,
  output logic                                     full,
  output logic                                     empty
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned CW = $clog2(COMMIT_WIDTH + 1);

  typedef logic [PW-1:0] ptr_t;

  sdq_entry_t       entries [DEPTH];
  ptr_t             head, cmt_ptr, tail;
  ptr_t             alloc_num, cmt_next, flush_span, uncommitted;
  sdq_drain_state_t state, state_next;
  sdq_entry_t       head_entry;
  logic             issue, retire;

  assign count       = tail - head;
  assign empty       = (tail == head);
  assign full        = (tail[IW-1:0] == head[IW-1:0]) && (tail[IW] != head[IW]);
  assign tail_marker = tail;
  assign head_entry  = entries[head[IW-1:0]];
  assign cmt_next    = cmt_ptr + ptr_t'(commit_cnt);
  assign flush_span  = tail - cmt_next;
  assign uncommitted = tail - cmt_ptr;

  always_comb begin
    alloc_num = '0;
    for (int unsigned s = 0; s < ALLOC_WIDTH; s++) begin
      alloc_idx[s] = tail[IW-1:0] + alloc_num[IW-1:0];
      alloc_num    = alloc_num + ptr_t'(alloc_req[s]);
    end
    alloc_ready = (ptr_t'(DEPTH) - count) >= alloc_num;
  end

  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    issue         = 1'b0;
    retire        = 1'b0;
    case (state)
      SDQ_IDLE:
        if (!empty && head_entry.valid && head_entry.committed &&
            head_entry.addr_valid && !head_entry.issued)
          state_next = SDQ_REQ;
      SDQ_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          issue      = 1'b1;
          state_next = SDQ_WAIT_ACK;
        end
      end
      SDQ_WAIT_ACK:
        if (mem_ack) begin
          retire     = 1'b1;
          state_next = SDQ_IDLE;
        end
      default: state_next = SDQ_IDLE;
    endcase
  end

  assign mem_req_addr = mem_req_valid ? head_entry.addr : '0;
  assign mem_req_data = mem_req_valid ? head_entry.data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SDQ_IDLE;
    else     state <= state_next;
  end

  // Later assignments win: flush invalidation overrides writeback, and allocation is skipped on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      cmt_ptr <= '0;
      tail    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (wr_valid && entries[wr_idx].valid) begin
        entries[wr_idx].addr       <= wr_addr;
        entries[wr_idx].data       <= wr_data;
        entries[wr_idx].addr_valid <= 1'b1;
      end
      if (issue) entries[head[IW-1:0]].issued <= 1'b1;
      if (retire) begin
        entries[head[IW-1:0]] <= '0;
        head <= head + ptr_t'(1);
      end
      for (int unsigned j = 0; j < COMMIT_WIDTH; j++)
        if (CW'(j) < commit_cnt) entries[cmt_ptr[IW-1:0] + IW'(j)].committed <= 1'b1;
      cmt_ptr <= cmt_next;
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          if ({1'b0, IW'(i) - cmt_next[IW-1:0]} < flush_span) entries[i].valid <= 1'b0;
        tail <= cmt_next;
      end else if (alloc_ready) begin
        for (int unsigned s = 0; s < ALLOC_WIDTH; s++)
          if (alloc_req[s]) begin
            entries[alloc_idx[s]]       <= '0;
            entries[alloc_idx[s]].valid <= 1'b1;
          end
        tail <= tail + alloc_num;
      end
    end
  end

  commit_overrun: assert property (@(posedge clk) disable iff (rst) ptr_t'(commit_cnt) <= uncommitted);

  sdq_fwd_search #(.DEPTH(DEPTH)) u_fwd_search (
    .entries      (entries),
    .head         (head),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_marker    (ld_marker),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .fwd_conflict (fwd_conflict)
  );
endmodule

// File: tb/tb_store_data_queue.sv
// Self-checking bench for store_data_queue against an integer-pointer queue model.
module tb_store_data_queue;
  localparam int D  = 16;
  localparam int IW = 4;
  localparam int PW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] alloc_req;
  logic alloc_ready;
  logic [1:0][IW-1:0] alloc_idx;
  logic wr_valid;
  logic [IW-1:0] wr_idx;
  logic [31:0] wr_addr, wr_data;
  logic [1:0] commit_cnt;
  logic flush;
  logic mem_req_valid, mem_req_ready, mem_ack;
  logic [31:0] mem_req_addr, mem_req_data;
  logic ld_valid;
  logic [31:0] ld_addr;
  logic [PW-1:0] ld_marker;
  logic fwd_hit, fwd_conflict;
  logic [31:0] fwd_data;
  logic [PW-1:0] tail_marker, count;
  logic full, empty;

  int checks = 0;
  int errors = 0;

  // Model: unbounded integer pointers; entry state kept per slot.
  int m_head, m_cmt, m_tail, m_st;
  bit m_valid [D];
  bit m_av [D];
  logic [31:0] m_addr [D];
  logic [31:0] m_data [D];

  always #5 clk = ~clk;

  store_data_queue #(.DEPTH(D), .ALLOC_WIDTH(2), .COMMIT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_cnt(commit_cnt), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_ack(mem_ack),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_marker(ld_marker),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict),
    .tail_marker(tail_marker), .count(count), .full(full), .empty(empty)
  );

  function automatic void model_reset();
    m_head = 0; m_cmt = 0; m_tail = 0; m_st = 0;
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 0; m_av[i] = 0; m_addr[i] = '0; m_data[i] = '0;
    end
  endfunction

  function automatic int popc(logic [1:0] r);
    return int'(r[0]) + int'(r[1]);
  endfunction

  function automatic bit m_alloc_ready();
    return (D - (m_tail - m_head)) >= popc(alloc_req);
  endfunction

  // Youngest-first scan: the first unknown address before a match is a conflict.
  task automatic m_fwd(output bit hit, output logic [31:0] d, output bit conf);
    int n, p;
    hit = 0; d = '0; conf = 0;
    if (!ld_valid) return;
    n = (int'(ld_marker) - (m_head % (2*D)) + 2*D) % (2*D);
    for (int k = n - 1; k >= 0; k--) begin
      p = (m_head + k) % D;
      if (m_valid[p]) begin
        if (!m_av[p]) begin conf = 1; break; end
        if (m_addr[p][31:2] == ld_addr[31:2]) begin hit = 1; d = m_data[p]; break; end
      end
    end
  endtask

  function automatic logic [31:0] addr_pool();
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0: b = 32'h40;
      1: b = 32'h44;
      2: b = 32'h80;
      default: b = 32'h1000;
    endcase
    return b | 32'($urandom_range(0, 3));
  endfunction

  task automatic drive_idle();
    alloc_req = '0; wr_valid = 0; wr_idx = '0; wr_addr = '0; wr_data = '0;
    commit_cnt = '0; flush = 0; mem_req_ready = 0; mem_ack = 0;
    ld_valid = 0; ld_addr = '0; ld_marker = '0;
  endtask

  task automatic tick();
    bit ar;
    int h;
    ar = m_alloc_ready();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      h = m_head % D;
      case (m_st)
        0: if (m_head < m_cmt && m_av[h]) m_st = 1;
        1: if (mem_req_ready) m_st = 2;
        default: if (mem_ack) begin m_valid[h] = 0; m_av[h] = 0; m_head++; m_st = 0; end
      endcase
      if (wr_valid && m_valid[wr_idx]) begin
        m_addr[wr_idx] = wr_addr; m_data[wr_idx] = wr_data; m_av[wr_idx] = 1;
      end
      m_cmt = m_cmt + int'(commit_cnt);
      if (flush) begin
        for (int p = m_cmt; p < m_tail; p++) m_valid[p % D] = 0;
        m_tail = m_cmt;
      end else if (ar) begin
        for (int s = 0; s < 2; s++)
          if (alloc_req[s]) begin m_valid[m_tail % D] = 1; m_av[m_tail % D] = 0; m_tail++; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    tick();
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    ld_valid = 1; ld_marker = 5'd3; ld_addr = 32'h40;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (tail_marker !== 5'd0) begin errors++; $display("FAIL reset_tail: got %0d expected 0", tail_marker); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (fwd_hit !== 1'b0 || fwd_conflict !== 1'b0) begin errors++; $display("FAIL reset_fwd: got hit %b conflict %b expected 0 0", fwd_hit, fwd_conflict); end
    ld_valid = 0;
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      alloc_req = 2'b11;
      #1;
      checks++; if (alloc_ready !== 1'b1 || alloc_idx[0] !== IW'(2*c) || alloc_idx[1] !== IW'(2*c+1)) begin
        errors++; $display("FAIL fill_grant: got ready %b idx %0d/%0d expected 1 %0d/%0d", alloc_ready, alloc_idx[0], alloc_idx[1], 2*c, 2*c+1);
      end
      tick();
    end
    #1;
    checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL fill_full: got full %b count %0d expected 1 16", full, count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_not_ready: got %b expected 0", alloc_ready); end
    alloc_req = 2'b01;
    tick();
    alloc_req = 2'b00;
    #1;
    checks++; if (count !== 5'd16 || tail_marker !== 5'd16) begin errors++; $display("FAIL fill_17th: got count %0d tail %0d expected 16 16", count, tail_marker); end
  endtask

  task automatic test_drain();
    int w;
    do_reset();
    alloc_req = 2'b01; tick(); alloc_req = 2'b00;
    wr_valid = 1; wr_idx = 4'd0; wr_addr = 32'h100; wr_data = 32'hAA; tick(); wr_valid = 0;
    commit_cnt = 2'd1; tick(); commit_cnt = 2'd0;
    mem_req_ready = 1;
    w = 0;
    while (!mem_req_valid && w < 10) begin tick(); w++; end
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_data !== 32'hAA) begin
      errors++; $display("FAIL drain_req: got v %b addr %h data %h expected 1 100 aa", mem_req_valid, mem_req_addr, mem_req_data);
    end
    tick(); mem_req_ready = 0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL drain_wait: got v %b count %0d expected 0 1", mem_req_valid, count); end
    mem_ack = 1; tick(); mem_ack = 0;
    #1;
    checks++; if (count !== 5'd0 || 5'(tail_marker - count) !== 5'd1) begin
      errors++; $display("FAIL drain_ack: got count %0d head %0d expected 0 1", count, 5'(tail_marker - count));
    end
  endtask

  task automatic test_forward();
    do_reset();
    alloc_req = 2'b11; tick(); tick(); alloc_req = 2'b00;
    wr_valid = 1; wr_idx = 4'd2; wr_addr = 32'h40; wr_data = 32'h11; tick();
    wr_idx = 4'd3; wr_addr = 32'h40; wr_data = 32'h22; tick(); wr_valid = 0;
    ld_valid = 1; ld_marker = 5'd4; ld_addr = 32'h40; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22 || fwd_conflict !== 1'b0) begin
      errors++; $display("FAIL fwd_youngest: got hit %b data %h conf %b expected 1 22 0", fwd_hit, fwd_data, fwd_conflict);
    end
    ld_marker = 5'd3; ld_addr = 32'h43; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin
      errors++; $display("FAIL fwd_marker3: got hit %b data %h expected 1 11", fwd_hit, fwd_data);
    end
    ld_valid = 0; #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0 || fwd_conflict !== 1'b0) begin
      errors++; $display("FAIL fwd_ld_idle: got hit %b data %h conf %b expected 0 0 0", fwd_hit, fwd_data, fwd_conflict);
    end
    do_reset();
    alloc_req = 2'b11; tick(); tick(); alloc_req = 2'b00;
    wr_valid = 1; wr_idx = 4'd2; wr_addr = 32'h40; wr_data = 32'h11; tick(); wr_valid = 0;
    ld_valid = 1; ld_marker = 5'd4; ld_addr = 32'h40; #1;
    checks++; if (fwd_conflict !== 1'b1 || fwd_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_conflict: got conf %b hit %b expected 1 0", fwd_conflict, fwd_hit);
    end
    ld_valid = 0;
  endtask

  task automatic test_flush();
    int w;
    do_reset();
    alloc_req = 2'b11; tick(); tick(); tick(); alloc_req = 2'b00;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1; wr_idx = IW'(i); wr_addr = 32'h200 + 32'(4*i); wr_data = 32'(i + 1); tick();
    end
    wr_valid = 0;
    commit_cnt = 2'd2; tick();
    commit_cnt = 2'd1; flush = 1; alloc_req = 2'b11; tick();
    commit_cnt = 2'd0; flush = 0; alloc_req = 2'b00;
    #1;
    checks++; if (tail_marker !== 5'd3 || count !== 5'd3) begin errors++; $display("FAIL flush_tail: got tail %0d count %0d expected 3 3", tail_marker, count); end
    ld_valid = 1; ld_marker = 5'd6; ld_addr = 32'h210; #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_conflict !== 1'b0) begin errors++; $display("FAIL flush_invalid: got hit %b conf %b expected 0 0", fwd_hit, fwd_conflict); end
    ld_valid = 0;
    for (int k = 0; k < 3; k++) begin
      mem_req_ready = 1;
      w = 0;
      while (!mem_req_valid && w < 20) begin tick(); w++; end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 + 32'(4*k)) begin
        errors++; $display("FAIL flush_drain: got v %b addr %h expected 1 %h", mem_req_valid, mem_req_addr, 32'h200 + 32'(4*k));
      end
      tick(); mem_req_ready = 0;
      mem_ack = 1; tick(); mem_ack = 0;
    end
    #1;
    checks++; if (empty !== 1'b1 || tail_marker !== 5'd3) begin errors++; $display("FAIL flush_done: got empty %b tail %0d expected 1 3", empty, tail_marker); end
  endtask

  task automatic test_reset_mid_drain();
    int w;
    do_reset();
    alloc_req = 2'b01; tick(); alloc_req = 2'b00;
    wr_valid = 1; wr_idx = 4'd0; wr_addr = 32'h300; wr_data = 32'h5; tick(); wr_valid = 0;
    commit_cnt = 2'd1; tick(); commit_cnt = 2'd0;
    mem_req_ready = 1;
    w = 0;
    while (!mem_req_valid && w < 10) begin tick(); w++; end
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL midrst_req: got %b expected 1", mem_req_valid); end
    tick(); mem_req_ready = 0;
    #1 rst = 1;
    #1 rst = 0;
    model_reset();
    mem_ack = 1; tick(); mem_ack = 0;
    #1;
    checks++; if (empty !== 1'b1 || count !== 5'd0 || tail_marker !== 5'd0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state: got empty %b count %0d tail %0d v %b expected 1 0 0 0", empty, count, tail_marker, mem_req_valid);
    end
  endtask

  task automatic test_random();
    int occ, p, maxc, lower;
    bit e_hit, e_conf;
    logic [31:0] e_data;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      occ = m_tail - m_head;
      alloc_req = 2'($urandom_range(0, 3));
      wr_valid = 0;
      if (occ > 0 && $urandom_range(0, 1) == 1) begin
        p = m_head + int'($urandom_range(0, occ - 1));
        if (!(p < m_cmt && m_av[p % D])) begin wr_valid = 1; wr_idx = IW'(p % D); end
      end else if ($urandom_range(0, 9) == 0) begin
        p = int'($urandom_range(0, D - 1));
        if (!m_valid[p]) begin wr_valid = 1; wr_idx = IW'(p); end
      end
      wr_addr = addr_pool(); wr_data = $urandom;
      maxc = m_tail - m_cmt; if (maxc > 2) maxc = 2;
      commit_cnt = 2'($urandom_range(0, maxc));
      flush = ($urandom_range(0, 29) == 0);
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_ack = ($urandom_range(0, 2) == 0);
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_marker = PW'((m_head + int'($urandom_range(0, occ))) % (2*D));
      ld_addr = addr_pool();
      #1;
      checks++; if (count !== PW'(occ)) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", count, occ); end
      checks++; if (full !== (occ == D) || empty !== (occ == 0)) begin errors++; $display("FAIL rnd_flags: got full %b empty %b occ %0d", full, empty, occ); end
      checks++; if (tail_marker !== PW'(m_tail % (2*D))) begin errors++; $display("FAIL rnd_tail: got %0d expected %0d", tail_marker, m_tail % (2*D)); end
      checks++; if (alloc_ready !== m_alloc_ready()) begin errors++; $display("FAIL rnd_alloc_ready: got %b expected %b", alloc_ready, m_alloc_ready()); end
      lower = 0;
      for (int s = 0; s < 2; s++)
        if (alloc_req[s]) begin
          checks++; if (alloc_idx[s] !== IW'((m_tail + lower) % D)) begin errors++; $display("FAIL rnd_alloc_idx: got %0d expected %0d", alloc_idx[s], (m_tail + lower) % D); end
          lower++;
        end
      checks++; if (mem_req_valid !== (m_st == 1)) begin errors++; $display("FAIL rnd_mem_valid: got %b expected %b", mem_req_valid, m_st == 1); end
      if (m_st == 1) begin
        checks++; if (mem_req_addr !== m_addr[m_head % D] || mem_req_data !== m_data[m_head % D]) begin
          errors++; $display("FAIL rnd_mem_payload: got %h/%h expected %h/%h", mem_req_addr, mem_req_data, m_addr[m_head % D], m_data[m_head % D]);
        end
      end
      m_fwd(e_hit, e_data, e_conf);
      checks++; if (fwd_hit !== e_hit || fwd_conflict !== e_conf || fwd_data !== e_data) begin
        errors++; $display("FAIL rnd_fwd: got %b/%b/%h expected %b/%b/%h", fwd_hit, fwd_conflict, fwd_data, e_hit, e_conf, e_data);
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_forward();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
